fan_tacho_gate: RTL and testbench

Upstream measurement stage of the fan controller. It synchronises and deglitches the open-collector tachometer input, counts filtered rising edges over a programmable gate window of timebase ticks, and presents the saturated count as the speed value that feeds the PID core's ADC input. It also produces the one-cycle strobe that advances the PID core, so each PID update consumes exactly one fresh measurement.

---
 rtl/fan_tacho_gate.sv | 83 ++++++++
 tb/tb_fan_tacho_gate.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fan_tacho_gate.sv
// Tachometer front end: synchronise and deglitch the tach pin, count filtered rising
// edges over a gate of timebase ticks, and strobe the PID core once per window.
module fan_tacho_gate #(
  parameter int ADC_BITWIDTH  = 8,
  parameter int GATE_BITWIDTH = 10,
  parameter int FILTER_CYCLES = 8
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     clk_en_i,
  input  logic                     tach_i,
  input  logic [GATE_BITWIDTH-1:0] gateTicks_i,
  output logic [ADC_BITWIDTH-1:0]  ADC_value_o,
  output logic                     clk_en_PID_o,
  output logic                     stall_o
);

  localparam int                FCW      = 8;
  localparam logic [FCW-1:0]    FLT_LAST = FCW'(FILTER_CYCLES - 1);

  logic                     tach_s1, tach_s2;
  logic                     filt, filt_d;
  logic [FCW-1:0]           flt_cnt;
  logic [ADC_BITWIDTH-1:0]  edge_cnt, cnt_next;
  logic [GATE_BITWIDTH-1:0] timer, gate_last;
  logic                     edge_ev, gate_on, win_end;

  // Synchroniser and glitch filter: a new level must persist FILTER_CYCLES clocks.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tach_s1 <= 1'b0;
      tach_s2 <= 1'b0;
      filt    <= 1'b0;
      filt_d  <= 1'b0;
      flt_cnt <= '0;
    end else begin
      tach_s1 <= tach_i;
      tach_s2 <= tach_s1;
      filt_d  <= filt;
      if (tach_s2 == filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt >= FLT_LAST) begin
        filt    <= ~filt;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + FCW'(1);
      end
    end
  end

  assign edge_ev   = filt & ~filt_d;
  assign gate_on   = |gateTicks_i;
  assign gate_last = gateTicks_i - GATE_BITWIDTH'(1);
  // >= rather than == so a gate shrunk below the running timer closes on the next tick.
  assign win_end   = gate_on & clk_en_i & (timer >= gate_last);
  // Saturating count including this cycle's event, so a closing-tick edge is kept.
  assign cnt_next  = (edge_ev && !(&edge_cnt)) ? edge_cnt + ADC_BITWIDTH'(1) : edge_cnt;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      timer        <= '0;
      edge_cnt     <= '0;
      ADC_value_o  <= '0;
      clk_en_PID_o <= 1'b0;
      stall_o      <= 1'b1;
    end else begin
      clk_en_PID_o <= win_end;
      if (!gate_on) begin
        timer    <= '0;
        edge_cnt <= '0;
      end else if (win_end) begin
        timer       <= '0;
        edge_cnt    <= '0;
        ADC_value_o <= cnt_next;
        stall_o     <= (cnt_next == '0);
      end else begin
        edge_cnt <= cnt_next;
        if (clk_en_i) timer <= timer + GATE_BITWIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fan_tacho_gate.sv
// Directed and randomized bench for fan_tacho_gate; a cycle model built from run
// lengths of the tach pin and tick counting predicts every output on every clock.
module tb_fan_tacho_gate;
  localparam int AW   = 8;
  localparam int GW   = 10;
  localparam int F    = 8;
  localparam int AMAX = (1 << AW) - 1;

  logic          clk_i = 1'b0, rstn_i = 1'b1, clk_en_i = 1'b0, tach_i = 1'b0;
  logic [GW-1:0] gateTicks_i = '0;
  logic [AW-1:0] ADC_value_o;
  logic          clk_en_PID_o, stall_o;

  fan_tacho_gate #(.ADC_BITWIDTH(AW), .GATE_BITWIDTH(GW), .FILTER_CYCLES(F)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .clk_en_i(clk_en_i), .tach_i(tach_i),
    .gateTicks_i(gateTicks_i), .ADC_value_o(ADC_value_o),
    .clk_en_PID_o(clk_en_PID_o), .stall_o(stall_o));

  always #5 clk_i = ~clk_i;

  int   vectors = 0, errors = 0;
  int   m_cnt, m_ticks, m_adc;
  logic m_stb, m_stall, m_filt, m_filt_d;
  logic hist[$];
  int   cyc, en_per, nstb, first_stb, n0, held;
  int   hi_lo, hi_hi, lo_lo, lo_hi, seg_left;
  logic seg_lvl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_ticks = 0; m_adc = 0; m_stb = 1'b0; m_stall = 1'b1;
    m_filt = 1'b0; m_filt_d = 1'b0;
    hist.delete(); hist.push_back(1'b0); hist.push_back(1'b0);
  endtask

  // hist holds raw pin samples; the filter acts on the sample two clocks old and
  // flips once the last F of those all disagree with the current level.
  task automatic model_edge(input logic t, input logic en, input int g);
    logic ev, dis;
    int   n, tot;
    ev  = m_filt & ~m_filt_d;
    tot = m_cnt + int'(ev);
    m_stb = (g != 0) && en && (m_ticks + 1 >= g);
    if (g == 0) begin
      m_cnt = 0; m_ticks = 0;
    end else if (m_stb) begin
      m_adc = (tot > AMAX) ? AMAX : tot;
      m_stall = (tot == 0);
      m_cnt = 0; m_ticks = 0;
    end else begin
      m_cnt = tot;
      if (en) m_ticks++;
    end
    n = hist.size();
    dis = (n >= F + 1);
    for (int j = n - 1 - F; dis && j <= n - 2; j++)
      if (hist[j] == m_filt) dis = 1'b0;
    m_filt_d = m_filt;
    if (dis) m_filt = ~m_filt;
    hist.push_back(t);
    if (hist.size() > F + 4) hist.delete(0);
  endtask

  task automatic step(input logic t);
    logic en;
    en = (en_per == 0) ? 1'($urandom_range(0, 1)) : ((cyc % en_per) == en_per - 1);
    @(negedge clk_i);
    tach_i = t; clk_en_i = en;
    @(posedge clk_i);
    model_edge(t, en, int'(gateTicks_i));
    #1;
    chk("adc", ADC_value_o, m_adc);
    chk("strobe", clk_en_PID_o, m_stb);
    chk("stall", stall_o, m_stall);
    if (clk_en_PID_o === 1'b1) begin
      if (nstb == 0) first_stb = cyc;
      nstb++;
    end
    cyc++;
  endtask

  task automatic gen(output logic t);
    if (seg_left == 0) begin
      seg_lvl  = ~seg_lvl;
      seg_left = seg_lvl ? $urandom_range(hi_hi, hi_lo) : $urandom_range(lo_hi, lo_lo);
    end
    seg_left--;
    t = seg_lvl;
  endtask

  task automatic set_tach(input int hl, input int hh, input int ll, input int lh);
    hi_lo = hl; hi_hi = hh; lo_lo = ll; lo_hi = lh; seg_left = 0; seg_lvl = 1'b1;
  endtask

  task automatic run(input int n);
    logic t;
    for (int i = 0; i < n; i++) begin
      gen(t);
      step(t);
    end
  endtask

  task automatic level(input logic v, input int n);
    for (int i = 0; i < n; i++) step(v);
  endtask

  task automatic do_reset();
    @(posedge clk_i);
    #2 rstn_i = 1'b0;
    #1;
    chk("rst_adc", ADC_value_o, 0);
    chk("rst_strobe", clk_en_PID_o, 0);
    chk("rst_stall", stall_o, 1);
    tach_i = 1'b0; clk_en_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rstn_i = 1'b1;
    model_reset();
    cyc = 0; nstb = 0; first_stb = -1;
  endtask

  initial begin
    // Nominal setup, then a reset mid-window with five edges already counted.
    gateTicks_i = 10'd100; en_per = 4; set_tach(20, 20, 20, 20);
    do_reset();
    run(200);
    do_reset();
    run(400);
    chk("first_win_end", first_stb, 399);
    chk("first_win_count", nstb, 1);
    run(400);
    chk("nominal_adc", ADC_value_o, 10);
    chk("nominal_stall", stall_o, 0);
    run(400);
    chk("nominal_adc2", ADC_value_o, 10);
    chk("nominal_strobes", nstb, 3);

    // 7-clk glitches dropped, 8-clk pulses counted.
    do_reset();
    gateTicks_i = 10'd200; en_per = 1;
    for (int i = 0; i < 3; i++) begin level(1'b1, 7); level(1'b0, 23); end
    for (int i = 0; i < 3; i++) begin level(1'b1, 8); level(1'b0, 22); end
    level(1'b0, 20);
    chk("deglitch_adc", ADC_value_o, 3);

    // Edge event on the closing tick belongs to the closing window.
    do_reset();
    gateTicks_i = 10'd20; en_per = 1;
    level(1'b0, 9);
    level(1'b1, 11);
    chk("coincide_strobe", clk_en_PID_o, 1);
    chk("coincide_adc", ADC_value_o, 1);
    level(1'b1, 20);
    chk("coincide_next_adc", ADC_value_o, 0);
    chk("coincide_next_stall", stall_o, 1);

    // Shrinking the gate below the timer closes the window on the next tick.
    do_reset();
    gateTicks_i = 10'd100; en_per = 1; set_tach(10, 14, 10, 14);
    run(50);
    gateTicks_i = 10'd20;
    run(1);
    chk("shrink_strobe", clk_en_PID_o, 1);
    run(60);

    // Gate of zero freezes outputs and strobes.
    held = m_adc; n0 = nstb;
    gateTicks_i = 10'd0;
    run(200);
    chk("gate0_adc", ADC_value_o, held);
    chk("gate0_strobes", nstb - n0, 0);
    gateTicks_i = 10'd15;
    run(100);

    // Saturation, then a small count, then a stall and a restart.
    do_reset();
    gateTicks_i = 10'd1000; en_per = 5; set_tach(8, 8, 8, 8);
    run(4980);
    level(1'b0, 20);
    chk("sat_strobe", clk_en_PID_o, 1);
    chk("sat_adc", ADC_value_o, AMAX);
    level(1'b0, 10);
    for (int i = 0; i < 3; i++) begin level(1'b1, 20); level(1'b0, 20); end
    level(1'b0, 4870);
    chk("post_sat_adc", ADC_value_o, 3);
    gateTicks_i = 10'd100; en_per = 4;
    level(1'b0, 400);
    chk("stall_adc", ADC_value_o, 0);
    chk("stall_flag", stall_o, 1);
    set_tach(20, 20, 20, 20);
    run(400);
    chk("restart_stall", stall_o, 0);

    // Random gates, random ticks, random tach run lengths around the filter depth.
    do_reset();
    en_per = 0; set_tach(1, 20, 1, 20);
    for (int k = 0; k < 20; k++) begin
      gateTicks_i = GW'($urandom_range(1, 30));
      run(150);
    end
    gateTicks_i = 10'd1; en_per = 1;
    run(2);
    n0 = nstb;
    run(20);
    chk("gate1_strobes", nstb - n0, 20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
